// File: rtl/ram2e_dram_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ram2e_dram_sched
//  Purpose  : DRAM cycle scheduler for the RAM2E. Runs on C14M, locks onto
//             the Apple II PHI1 phase and divides every Apple cycle into a
//             video slot, a shared mid slot (refresh or auxiliary access)
//             and a CPU slot. Produces registered RAS/CAS, the row-address
//             select for the bank-bit mux, read-data latch strobes and slot
//             status.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    C14M     in   1  14.318 MHz clock, rising edge
//    nRST     in   1  asynchronous reset, active low
//    PHI1     in   1  Apple II PHI1 (asynchronous, registered once)
//    nEN80    in   1  80-column enable, active low; qualifies the CPU slot
//    AuxReq   in   1  auxiliary request, held until AuxAck
//    AuxAck   out  1  one-clock pulse, auxiliary data valid
//    nRAS     out  1  DRAM RAS, active low
//    nCAS     out  1  DRAM CAS, active low
//    RowSel   out  1  high while the row half of the bank address is driven
//    Slot     out  2  0 idle, 1 video, 2 mid (refresh/aux), 3 CPU
//    VidLatch out  1  latch video read data
//    CpuLatch out  1  latch CPU read data
//    AuxLatch out  1  latch aux read data
//    RefPend  out  2  pending refresh credits
// ============================================================================
module ram2e_dram_sched #(
    parameter int REF_DIV    = 13,  // Apple cycles per refresh credit
    parameter int REF_MAX    = 3,   // credit saturation value
    parameter int REF_URGENT = 2    // credits at which refresh beats aux
) (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       PHI1,
    input  logic       nEN80,
    input  logic       AuxReq,
    output logic       AuxAck,
    output logic       nRAS,
    output logic       nCAS,
    output logic       RowSel,
    output logic [1:0] Slot,
    output logic       VidLatch,
    output logic       CpuLatch,
    output logic       AuxLatch,
    output logic [1:0] RefPend
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DIV_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(REF_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_one   = DIV_W'(1);
    localparam logic [1:0]       c_ref_max   = 2'(REF_MAX);
    localparam logic [1:0]       c_ref_urgent = 2'(REF_URGENT);

    localparam logic [3:0] c_s_idle = 4'd0;
    localparam logic [3:0] c_s_last = 4'd15;

    localparam logic [1:0] c_slot_idle = 2'd0;
    localparam logic [1:0] c_slot_vid  = 2'd1;
    localparam logic [1:0] c_slot_mid  = 2'd2;
    localparam logic [1:0] c_slot_cpu  = 2'd3;

    // Owner of the mid slot for the current Apple cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REF  = 2'd1,
        GNT_AUX  = 2'd2
    } grant_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             phi1_q,     phi1_d;
    logic             phi0seen_q, phi0seen_d;
    logic [3:0]       s_q,        s_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [1:0]       refpend_q,  refpend_d;
    grant_e           grant_q,    grant_d;
    logic             cpuen_q,    cpuen_d;

    logic             nras_q,   nras_d;
    logic             ncas_q,   ncas_d;
    logic             rowsel_q, rowsel_d;
    logic [1:0]       slot_q,   slot_d;
    logic             vidl_q,   vidl_d;
    logic             cpul_q,   cpul_d;
    logic             auxl_q,   auxl_d;
    logic             ack_q,    ack_d;

    logic             w_sync;
    logic             w_credit;
    logic             w_refdone;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            phi1_q     <= 1'b0;
            phi0seen_q <= 1'b0;
            s_q        <= c_s_idle;
            div_q      <= '0;
            refpend_q  <= 2'd0;
            grant_q    <= GNT_NONE;
            cpuen_q    <= 1'b0;
            nras_q     <= 1'b1;
            ncas_q     <= 1'b1;
            rowsel_q   <= 1'b0;
            slot_q     <= c_slot_idle;
            vidl_q     <= 1'b0;
            cpul_q     <= 1'b0;
            auxl_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            phi1_q     <= phi1_d;
            phi0seen_q <= phi0seen_d;
            s_q        <= s_d;
            div_q      <= div_d;
            refpend_q  <= refpend_d;
            grant_q    <= grant_d;
            cpuen_q    <= cpuen_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            rowsel_q   <= rowsel_d;
            slot_q     <= slot_d;
            vidl_q     <= vidl_d;
            cpul_q     <= cpul_d;
            auxl_q     <= auxl_d;
            ack_q      <= ack_d;
        end
    end

    // ------------------------------------------------------------------------
    // Phase tracking, arbitration and refresh bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        phi1_d     = PHI1;
        // Only accept a rising PHI1 once a low level has been registered, so
        // PHI1 already high when reset releases cannot fake a cycle start.
        phi0seen_d = phi0seen_q | ~phi1_q;
        w_sync     = PHI1 & ~phi1_q & phi0seen_q;

        // Sequencer: restart on sync, park at 0 before the first sync and at
        // 15 if PHI1 stops toggling.
        s_d = s_q;
        if (w_sync) begin
            s_d = 4'd1;
        end else if ((s_q != c_s_idle) && (s_q != c_s_last)) begin
            s_d = s_q + 4'd1;
        end

        // Mid-slot owner is fixed at S3 so a late AuxReq change cannot
        // disturb an access already under way.
        grant_d = grant_q;
        if (w_sync) begin
            grant_d = GNT_NONE;
        end else if (s_q == 4'd3) begin
            if (refpend_q >= c_ref_urgent) begin
                grant_d = GNT_REF;
            end else if (AuxReq) begin
                grant_d = GNT_AUX;
            end else if (refpend_q != 2'd0) begin
                grant_d = GNT_REF;
            end else begin
                grant_d = GNT_NONE;
            end
        end

        cpuen_d = cpuen_q;
        if (!w_sync && (s_q == 4'd5)) begin
            cpuen_d = ~nEN80;
        end

        // One refresh credit per REF_DIV cycle starts.
        w_credit = w_sync && (div_q == c_div_last);
        div_d    = div_q;
        if (w_sync) begin
            div_d = (div_q == c_div_last) ? '0 : (div_q + c_div_one);
        end

        // A credit is consumed when the refresh access is issued at S4.
        w_refdone = !w_sync && (s_q == 4'd4) && (grant_q == GNT_REF);

        refpend_d = refpend_q;
        case ({w_credit, w_refdone})
            2'b10: begin
                if (refpend_q < c_ref_max) begin
                    refpend_d = refpend_q + 2'd1;
                end
            end
            2'b01: begin
                if (refpend_q != 2'd0) begin
                    refpend_d = refpend_q - 2'd1;
                end
            end
            default: refpend_d = refpend_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Strobe decode. Each output is set up one clock ahead from the current
    // sequencer value so it appears registered for the following period.
    // ------------------------------------------------------------------------
    always_comb begin
        nras_d   = 1'b1;
        ncas_d   = 1'b1;
        rowsel_d = 1'b0;
        slot_d   = c_slot_idle;
        vidl_d   = 1'b0;
        cpul_d   = 1'b0;
        auxl_d   = 1'b0;
        ack_d    = 1'b0;

        if (w_sync) begin
            // Cycle start: open the video row; whatever was in progress is
            // dropped without latch or ack.
            nras_d = 1'b0;
        end else begin
            case (s_q)
                4'd1: begin
                    slot_d = c_slot_vid;
                    nras_d = 1'b0;
                end
                4'd2: begin
                    slot_d = c_slot_vid;
                    nras_d = 1'b0;
                    ncas_d = 1'b0;
                end
                4'd3: begin
                    slot_d = c_slot_vid;
                    ncas_d = 1'b0;
                    vidl_d = 1'b1;
                end
                4'd4: begin
                    slot_d = c_slot_mid;
                    if (grant_q == GNT_REF) begin
                        // CAS together with RAS: single-period refresh.
                        nras_d = 1'b0;
                        ncas_d = 1'b0;
                    end else if (grant_q == GNT_AUX) begin
                        rowsel_d = 1'b1;
                        nras_d   = 1'b0;
                    end
                end
                4'd5: begin
                    slot_d = c_slot_mid;
                    if (grant_q == GNT_AUX) begin
                        nras_d = 1'b0;
                        ncas_d = 1'b0;
                        auxl_d = 1'b1;
                        ack_d  = 1'b1;
                    end
                end
                4'd6: begin
                    slot_d   = c_slot_cpu;
                    rowsel_d = cpuen_q;
                end
                4'd7: begin
                    slot_d   = c_slot_cpu;
                    rowsel_d = cpuen_q;
                    nras_d   = ~cpuen_q;
                end
                4'd8, 4'd9: begin
                    slot_d = c_slot_cpu;
                    nras_d = ~cpuen_q;
                end
                4'd10: begin
                    slot_d = c_slot_cpu;
                    nras_d = ~cpuen_q;
                    ncas_d = ~cpuen_q;
                end
                4'd11: begin
                    slot_d = c_slot_cpu;
                    ncas_d = ~cpuen_q;
                    cpul_d = cpuen_q;
                end
                default: begin
                    slot_d = c_slot_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign nRAS     = nras_q;
    assign nCAS     = ncas_q;
    assign RowSel   = rowsel_q;
    assign Slot     = slot_q;
    assign VidLatch = vidl_q;
    assign CpuLatch = cpul_q;
    assign AuxLatch = auxl_q;
    assign AuxAck   = ack_q;
    assign RefPend  = refpend_q;

endmodule
`default_nettype wire

// File: tb/tb_ram2e_dram_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram2e_dram_sched
//  Purpose  : Self-checking bench for ram2e_dram_sched. Each Apple cycle the
//             bench plans the expected output vector for every C14M period
//             after the sync edge and queues it; the scenario tasks pop and
//             compare one entry per period.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram2e_dram_sched;

    logic       C14M   = 1'b0;
    logic       nRST   = 1'b0;
    logic       PHI1   = 1'b0;
    logic       nEN80  = 1'b0;
    logic       AuxReq = 1'b0;
    logic       AuxAck, nRAS, nCAS, RowSel, VidLatch, CpuLatch, AuxLatch;
    logic [1:0] Slot, RefPend;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed vector: {nRAS,nCAS,RowSel,Slot[1:0],Vid,Cpu,AuxL,Ack,RefPend[1:0]}
    logic [10:0] w_obs;
    assign w_obs = {nRAS, nCAS, RowSel, Slot, VidLatch, CpuLatch, AuxLatch, AuxAck, RefPend};

    localparam logic [10:0] c_idle = 11'b11_0_00_0000_00;
    localparam int G_NONE = 0;
    localparam int G_REF  = 1;
    localparam int G_AUX  = 2;

    logic [10:0] sb[$];
    int m_div  = 0;   // syncs since last credit
    int m_pend = 0;   // refresh credits

    ram2e_dram_sched dut (
        .C14M     (C14M),
        .nRST     (nRST),
        .PHI1     (PHI1),
        .nEN80    (nEN80),
        .AuxReq   (AuxReq),
        .AuxAck   (AuxAck),
        .nRAS     (nRAS),
        .nCAS     (nCAS),
        .RowSel   (RowSel),
        .Slot     (Slot),
        .VidLatch (VidLatch),
        .CpuLatch (CpuLatch),
        .AuxLatch (AuxLatch),
        .RefPend  (RefPend)
    );

    always #5 C14M = ~C14M;

    // Expected outputs in period k after the sync edge (k=1 is the period
    // right after the sync edge; outputs "at S=n" show up in period n+1).
    function automatic logic [10:0] exp_vec(input int k, input int g, input bit cpuen, input int pend);
        logic nras, ncas, rs, vid, cpu, al, ack;
        logic [1:0] slot;
        nras = 1'b1; ncas = 1'b1; rs = 1'b0; slot = 2'd0;
        vid = 1'b0; cpu = 1'b0; al = 1'b0; ack = 1'b0;
        if (k >= 1 && k <= 3) nras = 1'b0;
        if (k == 3 || k == 4) ncas = 1'b0;
        if (k >= 2 && k <= 4) slot = 2'd1;
        if (k == 4) vid = 1'b1;
        if (k == 5 || k == 6) slot = 2'd2;
        if (g == G_REF && k == 5) begin nras = 1'b0; ncas = 1'b0; end
        if (g == G_AUX) begin
            if (k == 5) rs = 1'b1;
            if (k == 5 || k == 6) nras = 1'b0;
            if (k == 6) begin ncas = 1'b0; al = 1'b1; ack = 1'b1; end
        end
        if (k >= 7 && k <= 12) slot = 2'd3;
        if (cpuen) begin
            if (k == 7 || k == 8) rs = 1'b1;
            if (k >= 8 && k <= 11) nras = 1'b0;
            if (k == 11 || k == 12) ncas = 1'b0;
            if (k == 12) cpu = 1'b1;
        end
        return {nras, ncas, rs, slot, vid, cpu, al, ack, 2'(pend)};
    endfunction

    // Advance the refresh/arbitration model by one sync and queue len
    // expected periods (len is at least 8 everywhere, so grant, refresh
    // decrement and CpuEn sampling all happen before the next sync).
    task automatic plan_cycle(input int len, input bit aux_s3, input bit cpuen);
        int g;
        int pre;
        if (m_div == 12) begin
            m_div = 0;
            if (m_pend < 3) m_pend++;
        end else begin
            m_div++;
        end
        pre = m_pend;
        if (pre >= 2)      g = G_REF;
        else if (aux_s3)   g = G_AUX;
        else if (pre > 0)  g = G_REF;
        else               g = G_NONE;
        if (g == G_REF) m_pend--;
        for (int k = 1; k <= len; k++)
            sb.push_back(exp_vec(k, g, cpuen, (k <= 4) ? pre : m_pend));
    endtask

    // PHI1 drive after sampling period k: drop at fall_k, rise at len so the
    // next edge is the following cycle's sync edge.
    task automatic phi_drive(input int k, input int fall_k, input int len);
        if (k == fall_k) PHI1 = 1'b0;
        if (k == len)    PHI1 = 1'b1;
    endtask

    task automatic test_reset;
        nRST = 1'b0; PHI1 = 1'b0; AuxReq = 1'b0; nEN80 = 1'b0;
        repeat (3) @(negedge C14M);
        n_tests++;
        if (w_obs !== c_idle) begin
            n_fail++;
            $display("FAIL reset_values got=%b want=%b", w_obs, c_idle);
        end
        // Release with PHI1 already high: no sync until it has been seen low.
        PHI1 = 1'b1;
        nRST = 1'b1;
        m_div = 0; m_pend = 0; sb.delete();
        for (int k = 1; k <= 12; k++) begin
            sb.push_back(c_idle);
            @(negedge C14M);
            n_tests++;
            if (w_obs !== sb[0]) begin
                n_fail++;
                $display("FAIL reset_nosync k=%0d got=%b want=%b", k, w_obs, sb[0]);
            end
            void'(sb.pop_front());
            if (k == 5)  PHI1 = 1'b0;
            if (k == 12) PHI1 = 1'b1;
        end
    endtask

    task automatic test_steady;
        for (int c = 0; c < 14; c++) begin
            plan_cycle(14, 1'b0, 1'b1);
            for (int k = 1; k <= 14; k++) begin
                @(negedge C14M);
                n_tests++;
                if (w_obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL steady c=%0d k=%0d got=%b want=%b", c, k, w_obs, sb[0]);
                end
                void'(sb.pop_front());
                phi_drive(k, 7, 14);
            end
        end
    endtask

    task automatic test_aux_held;
        AuxReq = 1'b1;
        for (int c = 0; c < 28; c++) begin
            plan_cycle(14, 1'b1, 1'b1);
            for (int k = 1; k <= 14; k++) begin
                @(negedge C14M);
                n_tests++;
                if (w_obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL aux_held c=%0d k=%0d got=%b want=%b", c, k, w_obs, sb[0]);
                end
                void'(sb.pop_front());
                phi_drive(k, 7, 14);
            end
        end
    endtask

    task automatic test_reset_mid;
        // AuxReq still high; reset lands at S=9 in the CPU access.
        plan_cycle(9, 1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge C14M);
            n_tests++;
            if (w_obs !== sb[0]) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d got=%b want=%b", k, w_obs, sb[0]);
            end
            void'(sb.pop_front());
            phi_drive(k, 7, 99);
        end
        #1 nRST = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== c_idle) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%b want=%b", w_obs, c_idle);
        end
        AuxReq = 1'b0;
        @(negedge C14M);
        nRST = 1'b1;
        m_div = 0; m_pend = 0; sb.delete();
        for (int k = 1; k <= 6; k++) begin
            sb.push_back(c_idle);
            @(negedge C14M);
            n_tests++;
            if (w_obs !== sb[0]) begin
                n_fail++;
                $display("FAIL reset_mid_idle k=%0d got=%b want=%b", k, w_obs, sb[0]);
            end
            void'(sb.pop_front());
            if (k == 6) PHI1 = 1'b1;
        end
    endtask

    task automatic test_aux_window;
        // c=0: request only after S3 -> no grant; c=1: high across S3 -> one access.
        for (int c = 0; c < 2; c++) begin
            plan_cycle(14, (c == 1), 1'b1);
            for (int k = 1; k <= 14; k++) begin
                @(negedge C14M);
                n_tests++;
                if (w_obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL aux_window c=%0d k=%0d got=%b want=%b", c, k, w_obs, sb[0]);
                end
                void'(sb.pop_front());
                phi_drive(k, 7, 14);
                if (c == 0 && k == 4) AuxReq = 1'b1;
                if (c == 0 && k == 8) AuxReq = 1'b0;
                if (c == 1 && k == 2) AuxReq = 1'b1;
                if (c == 1 && k == 4) AuxReq = 1'b0;
            end
        end
    endtask

    task automatic test_no80;
        nEN80 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            plan_cycle(14, 1'b0, 1'b0);
            for (int k = 1; k <= 14; k++) begin
                @(negedge C14M);
                n_tests++;
                if (w_obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL no80 c=%0d k=%0d got=%b want=%b", c, k, w_obs, sb[0]);
                end
                void'(sb.pop_front());
                phi_drive(k, 7, 14);
            end
        end
        nEN80 = 1'b0;
    endtask

    task automatic test_stall_abort;
        int lens[3]  = '{44, 8, 14};
        int falls[3] = '{40, 7, 7};
        for (int c = 0; c < 3; c++) begin
            plan_cycle(lens[c], 1'b0, 1'b1);
            for (int k = 1; k <= lens[c]; k++) begin
                @(negedge C14M);
                n_tests++;
                if (w_obs !== sb[0]) begin
                    n_fail++;
                    $display("FAIL stall_abort c=%0d k=%0d got=%b want=%b", c, k, w_obs, sb[0]);
                end
                void'(sb.pop_front());
                phi_drive(k, falls[c], lens[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_aux_held();
        test_reset_mid();
        test_aux_window();
        test_no80();
        test_stall_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ram2e_dram_sched.md
Name: ram2e_dram_sched

Overview:
- Cycle scheduler for the RAM2E DRAM, clocked from the 14M clock and synchronised to the Apple II PHI1 phase.
- Divides each Apple cycle into three fixed slots: video fetch, a shared mid slot, and a CPU access slot.
- The mid slot is arbitrated between DRAM refresh and an auxiliary requester (a future loader/DMA port) through a req/ack handshake.
- Emits registered nRAS/nCAS, a row-address select for the bank-bit mux, data-latch strobes and slot status.

Parameters:
- REF_DIV, 13: Apple cycles per refresh credit.
- REF_MAX, 3: refresh credit saturation value (2-bit counter).
- REF_URGENT, 2: pending credits at or above which refresh wins over aux.

Ports:
- C14M  in  1  14.318 MHz clock; all logic on its rising edge.
- nRST  in  1  asynchronous, active-low reset.
- PHI1  in  1  Apple II PHI1, asynchronous to sampling; registered once before use.
- nEN80  in  1  active-low 80-column enable; qualifies the CPU slot.
- AuxReq  in  1  aux access request; held high until AuxAck.
- AuxAck  out  1  one-C14M pulse when the aux data is valid.
- nRAS  out  1  DRAM RAS, active low.
- nCAS  out  1  DRAM CAS, active low.
- RowSel  out  1  high while the row half of the bank address is driven.
- Slot  out  2  current slot: 0 idle, 1 video, 2 mid (ref/aux), 3 CPU.
- VidLatch  out  1  pulse: latch video read data.
- CpuLatch  out  1  pulse: latch CPU read data.
- AuxLatch  out  1  pulse: latch aux read data.
- RefPend  out  2  pending refresh credits.

Behaviour:
- **Reset:** nRAS=nCAS=1; RowSel=0; Slot=0; all latch/ack strobes=0; S=0; PHI1reg=0; PHI0seen=0; RefPend=0; divider=0; Grant=NONE; CpuEn=0.
- **Outputs:** all registered. "At S=n" means the output is valid for the C14M period after the edge at which S held n.
- **Sync:**
  - PHI0seen is set when the registered PHI1 is 0.
  - Sync = PHI1 & ~PHI1reg & PHI0seen.
  - On Sync, S becomes 1. Otherwise S=0 holds, S=15 holds, and any other value increments.
  - Sync at any S (including mid-access) restarts at S1; the previous access is abandoned, with no ack and no latch.
  - If PHI1 stops, S saturates at 15 and all strobes stay inactive.
- **Video slot** (Slot=1 at S1–S3):
  - nRAS low at Sync edge, S1, S2.
  - nCAS low at S2, S3.
  - VidLatch at S3.
- **Grant:** latched at S3 using this priority:
  1. RefPend >= REF_URGENT → REF.
  2. Else AuxReq → AUX.
  3. Else RefPend > 0 → REF.
  4. Else NONE.
- **Mid slot** (Slot=2 at S4–S5):
  - REF: nRAS and nCAS both low at S4 only; RefPend decrements at S4.
  - AUX: RowSel high at S4; nRAS low at S4, S5; nCAS low at S5; AuxLatch and AuxAck at S5.
  - NONE: no strobes.
- **Aux handshake:**
  - AuxReq dropped before S3: no access.
  - AuxReq dropped after grant: the access completes and ack still pulses.
  - Exactly one ack per grant.
  - AuxReq still high after ack: eligible again next cycle.
- **CPU slot** (Slot=3 at S6–S11):
  - CpuEn = ~nEN80, sampled at S5.
  - If CpuEn: RowSel high at S6, S7; nRAS low at S7–S10; nCAS low at S10, S11; CpuLatch at S11.
  - If not CpuEn: no strobes, but Slot=3 still shown.
- **Slot encoding:** S0, S12–S15 → Slot=0.
- **Refresh divider:**
  - Counts Sync events 0..REF_DIV-1.
  - On wrap, RefPend increments, saturating at REF_MAX.
  - Increment and decrement on the same edge leave RefPend unchanged.
  - At saturation, further credits are dropped.
- **Invariants:**
  - nCAS is never low without nRAS low in the same or the preceding period.
  - nRAS never goes low at S0, S3, S12–S15.

Test Plan:
- Reset mid-CPU-access (S=9): nRAS/nCAS immediately 1, RefPend=0, then no strobes until a PHI1 low→high edge after PHI1 has been seen low.
- Steady PHI1 at 14 C14M/cycle, nEN80=0, AuxReq=0:
  - nRAS low at S1–2 and S7–10; nCAS low at S2–3 and S10–11; VidLatch at S3, CpuLatch at S11 every cycle.
  - A REF access every 13th cycle; RefPend peaks at 1.
- AuxReq held high, RefPend=0: AuxAck pulses at S5 every cycle; RowSel high at S4 and S6–7; RefPend climbs to 2, then the next cycle grants REF (no ack), after which aux resumes.
- AuxReq raised at S4 and dropped at S8: no grant, no AuxAck. AuxReq raised at S2 and dropped at S4: access completes with exactly one AuxAck.
- nEN80=1: video and refresh strobes unchanged; no nRAS in S7–S10, no CpuLatch, Slot=3 at S6–S11.
- PHI1 held high for 40 C14M: S saturates at 15 with no strobes. Then a Sync injected at S=8 restarts at S1 with no CpuLatch for the aborted cycle.
